// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit registers with optional read-only
// slots fed from user logic, per-register write pulses and flat register export.
module axi_lite_regbank #(
    parameter int                  ADDR_WIDTH = 8,
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [31:0]         RESET_VAL  = 32'h0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int         IDX_W  = ADDR_WIDTH - 2;
    localparam int         STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_held_q;
    logic                  w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [1:0]            rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;
    logic [NUM_REGS-1:0]   wr_pulse_d;

    logic                  commit;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic                  aw_ok;
    logic                  ar_ok;
    logic                  aw_ro;
    logic [NUM_REGS-1:0]   aw_sel;
    logic [DATA_WIDTH-1:0] rd_vals [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_mux;

    assign aw_idx = awaddr_q[ADDR_WIDTH-1:2];
    assign ar_idx = s_axi_araddr[ADDR_WIDTH-1:2];
    assign aw_ok  = (awaddr_q[1:0] == 2'b00) && (32'(aw_idx) < 32'(NUM_REGS));
    assign ar_ok  = (s_axi_araddr[1:0] == 2'b00) && (32'(ar_idx) < 32'(NUM_REGS));
    assign aw_ro  = |(aw_sel & RO_MASK);

    // A commit needs both halves of the write and a free response slot.
    assign commit     = aw_held_q && w_held_q && !bvalid_q;
    assign wr_pulse_d = (commit && aw_ok && !aw_ro) ? (aw_sel & ~RO_MASK) : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign aw_sel[gi] = (aw_idx == IDX_W'(gi));

            if (RO_MASK[gi]) begin : g_ro
                assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = ro_in[gi*DATA_WIDTH +: DATA_WIDTH];
            end else begin : g_rw
                logic [DATA_WIDTH-1:0] reg_q;
                logic                  unused_ro_bits;

                assign unused_ro_bits = ^ro_in[gi*DATA_WIDTH +: DATA_WIDTH];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        reg_q <= RESET_VAL;
                    end else if (wr_pulse_d[gi]) begin
                        for (int b = 0; b < STRB_W; b++) begin
                            if (wstrb_q[b]) begin
                                reg_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
                            end
                        end
                    end
                end

                assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = reg_q;
            end

            assign rd_vals[gi] = reg_out[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_mux = rd_vals[i];
            end
        end
    end

    // AW and W are captured independently; the held flags double as the inverse readies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;

            if (s_axi_awvalid && !aw_held_q) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axi_awaddr;
            end else if (commit) begin
                aw_held_q <= 1'b0;
            end

            if (s_axi_wvalid && !w_held_q) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end else if (commit) begin
                w_held_q <= 1'b0;
            end

            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= (aw_ok && !aw_ro) ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read data is captured on the AR edge, so a same-edge commit is not yet visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (s_axi_arvalid && !rvalid_q) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_ok ? rd_mux : '0;
            rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axi_awready = !aw_held_q;
    assign s_axi_wready  = !w_held_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank: vector table of single transactions plus
// hand-built sequences for write ordering, back-pressure and same-edge read/commit.
module tb_axi_lite_regbank;

    localparam int            AW = 8;
    localparam int            NR = 16;
    localparam logic [NR-1:0] RO = 16'h0088;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     s_axi_awaddr;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [AW-1:0]     s_axi_araddr;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [NR*32-1:0]  reg_out;
    logic [NR*32-1:0]  ro_in;
    logic [NR-1:0]     wr_pulse;

    always #5 clk = ~clk;

    axi_lite_regbank #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt [NR];
    int exp_cnt   [NR];

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (wr_pulse[i]) pulse_cnt[i]++;
        end
    end

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
        int          pulse_reg;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic int pulse_diff();
        int d = 0;
        for (int i = 0; i < NR; i++) begin
            if (pulse_cnt[i] != exp_cnt[i]) d++;
        end
        return d;
    endfunction

    function automatic logic [31:0] exp_reset_read(input int i);
        if (i == 3) return 32'hCAFE0003;
        if (i == 7) return 32'h5555AAAA;
        return 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        s_axi_bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            tick(); n++;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  s_axi_wvalid = 1'b0; end
        end
        while (!s_axi_bvalid && n < 50) begin tick(); n++; end
        if (!s_axi_bvalid) begin
            n_checks++; n_fail++;
            $display("FAIL write_timeout addr %h: got no bvalid, expected bvalid within 50 cycles", addr);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            resp = 2'bxx;
        end else begin
            resp = s_axi_bresp;
        end
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit done, hs;
        int n;
        done = 0; n = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        while (!done && n < 50) begin
            hs = s_axi_arvalid && s_axi_arready;
            tick(); n++;
            if (hs) begin done = 1; s_axi_arvalid = 1'b0; end
        end
        if (!done || !s_axi_rvalid) begin
            n_checks++; n_fail++;
            $display("FAIL read_timeout addr %h: got no rvalid, expected rvalid after AR", addr);
            s_axi_arvalid = 1'b0;
        end
        data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rsp;

        vecs[0]  = '{1'b1, 8'h04, 32'h11223344, 4'h5, 2'b00, 32'h0,        1};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00220044, -1};
        vecs[2]  = '{1'b1, 8'h40, 32'h99999999, 4'hF, 2'b10, 32'h0,        -1};
        vecs[3]  = '{1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0,        -1};
        vecs[4]  = '{1'b1, 8'h0C, 32'h12345678, 4'hF, 2'b10, 32'h0,        -1};
        vecs[5]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 2'b00, 32'hCAFE0003, -1};
        vecs[6]  = '{1'b0, 8'h40, 32'h0,        4'h0, 2'b10, 32'h0,        -1};
        vecs[7]  = '{1'b0, 8'h05, 32'h0,        4'h0, 2'b10, 32'h0,        -1};
        vecs[8]  = '{1'b1, 8'h3C, 32'hA5A5A5A5, 4'hF, 2'b00, 32'h0,        15};
        vecs[9]  = '{1'b1, 8'h3C, 32'h0000FF00, 4'h2, 2'b00, 32'h0,        15};
        vecs[10] = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'hA5A5FFA5, -1};
        vecs[11] = '{1'b1, 8'h3C, 32'h0,        4'h0, 2'b00, 32'h0,        15};
        vecs[12] = '{1'b0, 8'h3C, 32'h0,        4'h0, 2'b00, 32'hA5A5FFA5, -1};
        vecs[13] = '{1'b0, 8'h04, 32'h0,        4'h0, 2'b00, 32'h00220044, -1};
        vecs[14] = '{1'b0, 8'h08, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, -1};

        ro_in = '0;
        ro_in[3*32 +: 32] = 32'hCAFE0003;
        ro_in[7*32 +: 32] = 32'h5555AAAA;
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_awready", 32'(s_axi_awready), 32'd1);
        check("rst_wready", 32'(s_axi_wready), 32'd1);
        check("rst_arready", 32'(s_axi_arready), 32'd1);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_bresp_rresp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_wr_pulse", 32'(wr_pulse), 32'd0);

        // Every register reads its reset value (RO slots read ro_in)
        for (int i = 0; i < NR; i++) begin
            axi_read(8'(i * 4), rd, rsp);
            check($sformatf("reset_read_r%0d_data", i), rd, exp_reset_read(i));
            check($sformatf("reset_read_r%0d_resp", i), 32'(rsp), 32'd0);
        end

        // Reset in the middle of a pending read drops rvalid without a clock edge
        s_axi_araddr = 8'h08; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        check("midrst_rvalid_before", 32'(s_axi_rvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_rvalid_after", 32'(s_axi_rvalid), 32'd0);
        check("midrst_arready_after", 32'(s_axi_arready), 32'd1);
        tick();
        rst = 1'b0;
        tick();

        // W three cycles ahead of AW; response one cycle after the AW edge
        s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        tick();
        s_axi_wvalid = 1'b0;
        check("w_first_wready_low", 32'(s_axi_wready), 32'd0);
        check("w_first_awready_high", 32'(s_axi_awready), 32'd1);
        repeat (3) tick();
        check("w_first_no_bvalid", 32'(s_axi_bvalid), 32'd0);
        s_axi_awaddr = 8'h08; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("w_first_bvalid_E0", 32'(s_axi_bvalid), 32'd0);
        tick();
        check("w_first_bvalid_E1", 32'(s_axi_bvalid), 32'd1);
        check("w_first_bresp", 32'(s_axi_bresp), 32'd0);
        check("w_first_pulse_E1", 32'(wr_pulse), 32'h0004);
        check("w_first_reg2", reg_out[2*32 +: 32], 32'hDEADBEEF);
        tick();
        check("w_first_pulse_E2", 32'(wr_pulse), 32'h0);
        check("w_first_bvalid_held", 32'(s_axi_bvalid), 32'd1);
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("w_first_bvalid_done", 32'(s_axi_bvalid), 32'd0);
        exp_cnt[2]++;
        check("w_first_pulse_count", 32'(pulse_diff()), 32'd0);

        // Table-driven single transactions
        for (int i = 0; i < $size(vecs); i++) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rsp);
                if (vecs[i].pulse_reg >= 0) exp_cnt[vecs[i].pulse_reg]++;
                check($sformatf("vec%0d_wr_%h_bresp", i, vecs[i].addr), 32'(rsp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_wr_%h_pulses", i, vecs[i].addr), 32'(pulse_diff()), 32'd0);
            end else begin
                axi_read(vecs[i].addr, rd, rsp);
                check($sformatf("vec%0d_rd_%h_data", i, vecs[i].addr), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rd_%h_rresp", i, vecs[i].addr), 32'(rsp), 32'(vecs[i].exp_resp));
            end
        end
        check("ro_reg3_export", reg_out[3*32 +: 32], 32'hCAFE0003);

        // Read sampled on the commit edge returns the old value
        axi_write(8'h14, 32'h00001111, 4'hF, rsp);
        exp_cnt[5]++;
        s_axi_awaddr = 8'h14; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h22222222; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 8'h14; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        check("same_edge_rdata_old", s_axi_rdata, 32'h00001111);
        check("same_edge_reg5_new", reg_out[5*32 +: 32], 32'h22222222);
        check("same_edge_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        exp_cnt[5]++;
        check("same_edge_pulses", 32'(pulse_diff()), 32'd0);

        // Back-pressure: bready/rready low, second write waits behind bvalid
        s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hA1A1A1A1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        tick();
        check("bp_first_bvalid", 32'(s_axi_bvalid), 32'd1);
        s_axi_araddr = 8'h10; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        tick();
        s_axi_arvalid = 1'b0;
        s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'hB2B2B2B2; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_c%0d_stall", c),
                  {24'd0, s_axi_bvalid, s_axi_bresp, s_axi_rvalid, s_axi_rresp,
                   s_axi_awready, s_axi_wready},
                  {24'd0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0});
            check($sformatf("bp_c%0d_arready", c), 32'(s_axi_arready), 32'd0);
            check($sformatf("bp_c%0d_rdata", c), s_axi_rdata, 32'hA1A1A1A1);
            check($sformatf("bp_c%0d_reg4", c), reg_out[4*32 +: 32], 32'hA1A1A1A1);
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("bp_bvalid_released", 32'(s_axi_bvalid), 32'd0);
        tick();
        check("bp_second_bvalid", 32'(s_axi_bvalid), 32'd1);
        check("bp_second_reg4", reg_out[4*32 +: 32], 32'hB2B2B2B2);
        check("bp_rdata_still_old", s_axi_rdata, 32'hA1A1A1A1);
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        check("bp_rvalid_done", 32'(s_axi_rvalid), 32'd0);
        check("bp_arready_back", 32'(s_axi_arready), 32'd1);
        exp_cnt[4] += 2;
        check("bp_pulses", 32'(pulse_diff()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
